// File: rtl/cby_param_cfg_shadow.sv
// Parametrised Y-channel connection block with a double-buffered config chain.
// Optional CBY_CFG_PARITY_EN adds an even-parity bit at the tail of the chain.

module cby_ipin_mux #(
    parameter int CHAN_WIDTH = 5,
    parameter int TAPS       = 1,
    parameter int SEL_W      = 2,
    parameter int IDX        = 0
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [CHAN_WIDTH-1:0] bot_i,
    input  logic [CHAN_WIDTH-1:0] top_i,
    output logic                  pin_o
);
    logic [2*TAPS-1:0] hit;

    // Code j+1 taps track (IDX + j/2) mod CHAN_WIDTH; even j from bottom, odd j from top.
    // Codes 0 and anything above 2*TAPS leave every hit low, so the pin drives 0.
    for (genvar j = 0; j < 2*TAPS; j++) begin : g_tap
        localparam int T = (IDX + j/2) % CHAN_WIDTH;
        if (j % 2 == 0) begin : g_bot
            assign hit[j] = (sel_i == SEL_W'(j+1)) & bot_i[T];
        end else begin : g_top
            assign hit[j] = (sel_i == SEL_W'(j+1)) & top_i[T];
        end
    end

    assign pin_o = |hit;
endmodule

module cby_param_cfg_shadow #(
    parameter int CHAN_WIDTH = 5,
    parameter int NUM_IPIN   = 15,
    parameter int TAPS       = 1,
    parameter int SEL_W      = $clog2(2*TAPS+1),
    parameter int CFG_LEN    = NUM_IPIN*SEL_W
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  cfg_en,
    input  logic                  cfg_commit,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    output logic                  cfg_full,
    output logic                  cfg_valid,
    output logic                  cfg_err
);
`ifdef CBY_CFG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int  CHAIN_LEN = CFG_LEN + PAR_W;
    localparam int  CNT_W     = $clog2(CHAIN_LEN+1);
    localparam bit  ONE_SHOT  = (CHAIN_LEN == 1);

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_FULL} state_t;

    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CFG_LEN-1:0]   shadow_q;
    logic [CNT_W-1:0]     cnt_q;
    state_t               state_q;
    logic                 full_q, valid_q, err_q;
    logic                 parity_ok, commit_ok;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

`ifdef CBY_CFG_PARITY_EN
    assign parity_ok = ~(^sr_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign commit_ok = cfg_commit & ~cfg_en & (state_q == S_FULL) & parity_ok;

    always_comb begin
        sr_d = sr_q;
        if (cfg_en) sr_d = (sr_q << 1) | CHAIN_LEN'(ccff_head);
    end

    // One block owns chain, shadow and FSM so commit and shift priorities stay in one place.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q     <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_EMPTY;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sr_q <= sr_d;
            if (commit_ok) begin
                shadow_q <= sr_q[CFG_LEN-1:0];
                cnt_q    <= '0;
                state_q  <= S_EMPTY;
                full_q   <= 1'b0;
                valid_q  <= 1'b1;
            end else begin
                if (cfg_commit) err_q <= 1'b1;
                if (cfg_en) begin
                    case (state_q)
                        S_EMPTY: begin
                            cnt_q <= CNT_W'(1);
                            if (ONE_SHOT) begin
                                state_q <= S_FULL;
                                full_q  <= 1'b1;
                            end else begin
                                state_q <= S_LOADING;
                            end
                        end
                        S_LOADING: begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(CHAIN_LEN-1)) begin
                                state_q <= S_FULL;
                                full_q  <= 1'b1;
                            end
                        end
                        default: ; // FULL: shifts pass through, count stays saturated
                    endcase
                end
            end
        end
    end

    assign ccff_tail = sr_q[CHAIN_LEN-1];
    assign cfg_full  = full_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
        cby_ipin_mux #(
            .CHAN_WIDTH(CHAN_WIDTH),
            .TAPS      (TAPS),
            .SEL_W     (SEL_W),
            .IDX       (gi)
        ) u_mux (
            .sel_i(shadow_q[gi*SEL_W +: SEL_W]),
            .bot_i(chany_bottom_in),
            .top_i(chany_top_in),
            .pin_o(ipin_out[gi])
        );
    end
endmodule

// File: tb/tb_cby_param_cfg_shadow.sv
// Randomised + directed bench for cby_param_cfg_shadow against a queue-based model.
module tb_cby_param_cfg_shadow;
    localparam int CW      = 5;
    localparam int NI      = 15;
    localparam int TAPS    = 1;
    localparam int SEL_W   = 2;
    localparam int CFG_LEN = NI*SEL_W;
`ifdef CBY_CFG_PARITY_EN
    localparam int CHAIN   = CFG_LEN + 1;
`else
    localparam int CHAIN   = CFG_LEN;
`endif

    logic          prog_clk = 1'b0;
    logic          pReset, cfg_en, cfg_commit, ccff_head;
    logic          ccff_tail, cfg_full, cfg_valid, cfg_err;
    logic [CW-1:0] bot, top, bot_out, top_out;
    logic [NI-1:0] ipin_out;

    int n_chk = 0;
    int n_pass = 0;

    bit m_q[$];
    int m_fill;
    bit m_sh[CFG_LEN];
    bit m_valid, m_err;

    always #5 prog_clk = ~prog_clk;

    cby_param_cfg_shadow #(.CHAN_WIDTH(CW), .NUM_IPIN(NI), .TAPS(TAPS)) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .cfg_en          (cfg_en),
        .cfg_commit      (cfg_commit),
        .ccff_head       (ccff_head),
        .ccff_tail       (ccff_tail),
        .chany_bottom_in (bot),
        .chany_top_in    (top),
        .chany_bottom_out(bot_out),
        .chany_top_out   (top_out),
        .ipin_out        (ipin_out),
        .cfg_full        (cfg_full),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < CHAIN; k++) m_q.push_back(1'b0);
        m_fill = 0;
        for (int k = 0; k < CFG_LEN; k++) m_sh[k] = 1'b0;
        m_valid = 1'b0;
        m_err = 1'b0;
    endtask

    function automatic logic [NI-1:0] exp_ipin();
        logic [NI-1:0] e = '0;
        for (int i = 0; i < NI; i++) begin
            int code = 0;
            for (int b = 0; b < SEL_W; b++) code += int'(m_sh[i*SEL_W+b]) << b;
            if (code >= 1 && code <= 2*TAPS) begin
                int j = code - 1;
                int t = (i + j/2) % CW;
                e[i] = (j % 2 == 0) ? bot[t] : top[t];
            end
        end
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ipin"},  32'(ipin_out),  32'(exp_ipin()));
        chk({tag, "_tail"},  32'(ccff_tail), 32'(m_q[CHAIN-1]));
        chk({tag, "_full"},  32'(cfg_full),  32'(m_fill == CHAIN));
        chk({tag, "_valid"}, 32'(cfg_valid), 32'(m_valid));
        chk({tag, "_err"},   32'(cfg_err),   32'(m_err));
        chk({tag, "_topo"},  32'(top_out),   32'(bot));
        chk({tag, "_boto"},  32'(bot_out),   32'(top));
    endtask

    // One clock: apply inputs, advance the model on the edge, compare just after it.
    task automatic step(input logic en, input logic cm, input logic hd, input string tag);
        bit par = 1'b0;
        bit acc;
        cfg_en = en; cfg_commit = cm; ccff_head = hd;
        @(posedge prog_clk);
        foreach (m_q[k]) par ^= m_q[k];
`ifdef CBY_CFG_PARITY_EN
        acc = cm && !en && (m_fill == CHAIN) && !par;
`else
        acc = cm && !en && (m_fill == CHAIN);
`endif
        if (cm && !acc) m_err = 1'b1;
        if (acc) begin
            for (int k = 0; k < CFG_LEN; k++) m_sh[k] = m_q[k];
            m_valid = 1'b1;
            m_fill = 0;
        end
        if (en) begin
            m_q.push_front(hd);
            void'(m_q.pop_back());
            if (m_fill < CHAIN) m_fill++;
        end
        #1;
        cfg_en = 1'b0; cfg_commit = 1'b0;
        check_all(tag);
    endtask

    // Shift a configuration so that v ends up in sr[CFG_LEN-1:0] (with parity bit first).
    task automatic load_cfg(input logic [CFG_LEN-1:0] v, input string tag);
`ifdef CBY_CFG_PARITY_EN
        step(1'b1, 1'b0, ^v, tag);
`endif
        for (int k = CFG_LEN-1; k >= 0; k--) step(1'b1, 1'b0, v[k], tag);
    endtask

    task automatic do_reset();
        #2 pReset = 1'b0;
        model_reset();
        @(negedge prog_clk);
        pReset = 1'b1;
    endtask

    initial begin
        logic [CFG_LEN-1:0] v;
        pReset = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b0;
        bot = 5'b10110; top = 5'b01001;
        model_reset();
        #12;
        chk("t1_topo", 32'(top_out), 32'h16);
        chk("t1_boto", 32'(bot_out), 32'h09);
        chk("t1_ipin", 32'(ipin_out), 32'h0);
        chk("t1_tail", 32'(ccff_tail), 32'h0);
        chk("t1_flags", {29'd0, cfg_full, cfg_valid, cfg_err}, 32'h0);
        @(negedge prog_clk);
        pReset = 1'b1;

        // code 1 on ipin 0 -> bottom track 0
        bot = '0; top = '0;
        load_cfg(CFG_LEN'(1), "t2_load");
        chk("t2_full", 32'(cfg_full), 32'h1);
        step(1'b0, 1'b1, 1'b0, "t2_commit");
        chk("t2_vf", {30'd0, cfg_valid, cfg_full}, 32'h2);
        bot = 5'b00001; #1;
        chk("t2_sel_hi", 32'(ipin_out), 32'h1);
        bot = 5'b00000; #1;
        chk("t2_sel_lo", 32'(ipin_out), 32'h0);

        // code 2 -> top track 0; code 3 -> constant 0
        load_cfg(CFG_LEN'(2), "t3_load");
        step(1'b0, 1'b1, 1'b0, "t3_commit");
        bot = 5'b00000; top = 5'b00001; #1;
        chk("t3_top_hi", 32'(ipin_out), 32'h1);
        bot = 5'b11111; top = 5'b00000; #1;
        chk("t3_top_lo", 32'(ipin_out), 32'h0);
        load_cfg(CFG_LEN'(3), "t3_load3");
        step(1'b0, 1'b1, 1'b0, "t3_commit3");
        bot = 5'b11111; top = 5'b11111; #1;
        chk("t3_code3", 32'(ipin_out), 32'h0);

        // early commit rejected, loading continues
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, "t4_shift");
        step(1'b0, 1'b1, 1'b0, "t4_early");
        chk("t4_err", 32'(cfg_err), 32'h1);
        for (int k = 0; k < CHAIN-10; k++) begin
            step(1'b1, 1'b0, 1'b0, "t4_fill");
            if (k == CHAIN-12) chk("t4_notfull", 32'(cfg_full), 32'h0);
        end
        chk("t4_full", 32'(cfg_full), 32'h1);

        // commit with simultaneous shift rejected; tail latency
        do_reset();
        for (int k = 0; k < CHAIN; k++) step(1'b1, 1'b0, 1'b0, "t5_fill");
        step(1'b1, 1'b1, 1'b0, "t5_both");
        chk("t5_err_valid", {30'd0, cfg_err, cfg_valid}, 32'h2);
        step(1'b1, 1'b0, 1'b1, "t5_one");
        for (int k = 0; k < CHAIN-1; k++) begin
            if (k == CHAIN-2) chk("t5_tail_early", 32'(ccff_tail), 32'h0);
            step(1'b1, 1'b0, 1'b0, "t5_zero");
        end
        chk("t5_tail", 32'(ccff_tail), 32'h1);
        step(1'b1, 1'b0, 1'b0, "t5_extra");
        chk("t5_stillfull", 32'(cfg_full), 32'h1);

        // randomised traffic
        for (int c = 0; c < 600; c++) begin
            bot = CW'($urandom);
            top = CW'($urandom);
            step(($urandom % 10) < 7, ($urandom % 8) == 0, 1'($urandom), "rnd");
        end

        // async reset in the middle of loading
        v = CFG_LEN'($urandom);
        load_cfg(v, "t6_load");
        step(1'b0, 1'b1, 1'b0, "t6_commit");
        chk("t6_valid", 32'(cfg_valid), 32'h1);
        bot = 5'b11111; top = 5'b11111;
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'($urandom), "t6_shift");
        #2 pReset = 1'b0;
        #1;
        chk("t6_rst_ipin", 32'(ipin_out), 32'h0);
        chk("t6_rst_tail", 32'(ccff_tail), 32'h0);
        chk("t6_rst_flags", {29'd0, cfg_full, cfg_valid, cfg_err}, 32'h0);
        model_reset();
        @(negedge prog_clk);
        pReset = 1'b1;
        for (int k = 0; k < CHAIN-1; k++) step(1'b1, 1'b0, 1'b0, "t6_refill");
        chk("t6_notfull", 32'(cfg_full), 32'h0);
        step(1'b1, 1'b0, 1'b0, "t6_last");
        chk("t6_full", 32'(cfg_full), 32'h1);
`ifdef CBY_CFG_PARITY_EN
        step(1'b1, 1'b0, 1'b1, "t6_par");
        for (int k = 0; k < CHAIN-1; k++) step(1'b1, 1'b0, 1'b0, "t6_par");
        step(1'b0, 1'b1, 1'b0, "t6_badpar");
        chk("t6_par_err", {30'd0, cfg_err, cfg_valid}, 32'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
